serial_comp: RTL and testbench
==============================

SERIAL_COMP -- requirements
Module: serial_comp

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand length in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  begin a new comparison.
REQ-005 SHALL have port bit_valid  input  1  a/b carry a valid bit pair this cycle.
REQ-006 SHALL have port a  input  1  serial operand A bit.
REQ-007 SHALL have port b  input  1  serial operand B bit.
REQ-008 SHALL have port busy  output  1  comparison in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result final.
REQ-010 SHALL have port gt  output  1  A > B (unsigned).
REQ-011 SHALL have port eq  output  1  A == B.
REQ-012 SHALL have port lt  output  1  A < B (unsigned).

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; all outputs registered.
REQ-014 IDLE: start=1 -> SHIFT; bit counter cleared; working flags set to eq=1, gt=0, lt=0.
REQ-015 start SHALL be ignored in SHIFT and DONE; there is no restart mid-operation.
REQ-016 SHIFT: a bit pair is accepted only on cycles with bit_valid=1; bit_valid=0 stalls with all state held, no timeout.
REQ-017 Default order is MSB first: the first accepted pair with a!=b locks the result (a=1 -> gt, a=0 -> lt); later pairs do not change it.
REQ-018 Exactly one of gt/eq/lt SHALL be 1 whenever done=1.
REQ-019 After the WIDTH-th accepted pair: next state DONE. done=1 for exactly the one cycle spent in DONE, then IDLE.
REQ-020 Latency SHALL be one cycle from the edge accepting the last pair to done=1; the minimum start-to-done time is WIDTH+1 cycles.
REQ-021 busy=1 in SHIFT and DONE, 0 in IDLE.
REQ-022 gt/eq/lt SHALL hold the last result through IDLE until the next start; while busy they are undefined to the consumer.
REQ-023 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap; bit_valid after the WIDTH-th pair has no effect because the FSM has already left SHIFT.
REQ-024 start and bit_valid asserted in the same IDLE cycle: only start acts; that bit pair is not consumed.

Reset
REQ-025 rst_n=0 at a clk edge SHALL force IDLE, counter=0, busy=0, done=0, gt=0, eq=1, lt=0, in any state.
REQ-026 Reset mid-SHIFT SHALL discard the partial comparison and produce no done pulse.
REQ-027 rst_n SHALL have priority over start and bit_valid.

Configuration
REQ-028 Macro SERIAL_COMP_LSB_FIRST_EN SHALL select bit order at compile time.
REQ-029 Without SERIAL_COMP_LSB_FIRST_EN: MSB-first locking per REQ-017.
REQ-030 With SERIAL_COMP_LSB_FIRST_EN: LSB first; every accepted pair with a!=b overwrites the result (a=1 -> gt, else lt); pairs with a==b leave it unchanged; the final result equals that of the MSB-first ordering of the same operands.

Verification (WIDTH=4, MSB first unless noted)
REQ-031 start, A=1010, B=1001, bit_valid=1 every cycle -> done one cycle after 4th bit, gt=1 eq=0 lt=0.
REQ-032 A=0110, B=0110 -> eq=1; A=0011, B=0100 -> lt=1; done is a single-cycle pulse each time.
REQ-033 A=1010, B=1001 with bit_valid=0 for 3 cycles after the 2nd bit -> same result, done 3 cycles later; start pulses during SHIFT are ignored.
REQ-034 rst_n=0 after 2 bits -> next cycle busy=0, eq=1, no done; a following full comparison of A=0001, B=0000 gives gt=1.
REQ-035 With SERIAL_COMP_LSB_FIRST_EN, A=1010 (bits sent 0,1,0,1), B=1001 (bits sent 1,0,0,1) -> gt=1.

Source files
------------

// File: rtl/serial_comp.sv
// Bit-serial unsigned magnitude comparator: operands arrive one bit pair per accepted cycle.
// Compile-time option SERIAL_COMP_LSB_FIRST_EN switches from MSB-first to LSB-first bit order.
module serial_comp #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a,
  input  logic b,
  output logic busy,
  output logic done,
  output logic gt,
  output logic eq,
  output logic lt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b1;
      lt        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          // A bit pair presented alongside start is deliberately not consumed.
          if (start) begin
            state_reg <= SHIFT;
            busy      <= 1'b1;
            cnt_reg   <= '0;
            gt        <= 1'b0;
            eq        <= 1'b1;
            lt        <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
`ifdef SERIAL_COMP_LSB_FIRST_EN
            // Later (more significant) differing bits override earlier ones.
            if (a != b) begin
              eq <= 1'b0;
              gt <= a;
              lt <= ~a;
            end
`else
            // First differing bit is the most significant one and decides.
            if (eq && (a != b)) begin
              eq <= 1'b0;
              gt <= a;
              lt <= ~a;
            end
`endif
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_IDX) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_comp.sv
// Scoreboard bench for serial_comp at WIDTH=4; expected {gt,eq,lt} is queued at start and checked on done.
module tb_serial_comp;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n, start, bit_valid, a, b;
  logic busy, done, gt, eq, lt;

  int total = 0;
  int bad   = 0;
  int txn   = 0;
  logic [2:0] sb[$];
  logic done_prev = 1'b0;

  serial_comp #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
    .a(a), .b(b), .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    return {x > y, x == y, x < y};
  endfunction

  // Result monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (done_prev) check("done_pulse", 32'(done_prev), 32'd0);
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        logic [2:0] e;
        e = sb.pop_front();
        txn++;
        $display("txn %0d: gt=%0b eq=%0b lt=%0b expected %03b", txn, gt, eq, lt, e);
        check("result", 32'({gt, eq, lt}), 32'(e));
        check("onehot", 32'($countones({gt, eq, lt})), 32'd1);
      end
    end
    done_prev = done;
  end

  function automatic int bit_idx(input int i);
`ifdef SERIAL_COMP_LSB_FIRST_EN
    return i;
`else
    return W - 1 - i;
`endif
  endfunction

  // One full comparison; optional stall after bit 'stall_after' and start spam during SHIFT.
  task automatic do_cmp(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input int stall_after, input int stall_len,
                        input bit spam, input bit valid_with_start);
    sb.push_back(model(va, vb));
    @(posedge clk); #1;
    start = 1'b1;
    bit_valid = valid_with_start;
    a = 1'b1; b = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(posedge clk); #1;
      if (i == 0) check("busy_shift", 32'(busy), 32'd1);
      start = spam;
      bit_valid = 1'b1;
      a = va[bit_idx(i)];
      b = vb[bit_idx(i)];
      if (i == stall_after) begin
        for (int s = 0; s < stall_len; s++) begin
          bit_valid = 1'b0;
          a = ~a; b = ~b;
          @(posedge clk); #1;
          check("stall_no_done", 32'(done), 32'd0);
        end
        bit_valid = 1'b1;
        a = va[bit_idx(i)];
        b = vb[bit_idx(i)];
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    bit_valid = 1'b0;
    check("done_latency", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("done_drop", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("held", 32'({gt, eq, lt}), 32'(model(va, vb)));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; a = 1'b0; b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'({busy, done, gt, eq, lt}), 32'b00010);
    rst_n = 1'b1;

    // Example operands: gt, eq, lt.
    do_cmp(4'b1010, 4'b1001, -1, 0, 1'b0, 1'b0);
    do_cmp(4'b0110, 4'b0110, -1, 0, 1'b0, 1'b1);
    do_cmp(4'b0011, 4'b0100, -1, 0, 1'b0, 1'b0);
    // Three stall cycles after the 2nd bit, with start pulses ignored throughout.
    do_cmp(4'b1010, 4'b1001, 2, 3, 1'b1, 1'b0);
    do_cmp(4'b0000, 4'b1111, 0, 2, 1'b1, 1'b0);
    do_cmp(4'b1111, 4'b1110, -1, 0, 1'b0, 1'b0);

    // Reset after two bits: partial result discarded, no done.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bit_valid = 1'b1;
    a = 1'b1; b = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0; bit_valid = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_flags", 32'({done, gt, eq, lt}), 32'b0010);
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_nodone", 32'(busy), 32'd0);
    do_cmp(4'b0001, 4'b0000, -1, 0, 1'b0, 1'b0);

    // Random operands with random stalls.
    for (int k = 0; k < 10; k++) begin
      do_cmp(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
